wrapped_io_ctrl: RTL and testbench

//  Parametrised pad-control wrapper stage between the Caravel user-area pads and a user project.

---
 rtl/wrapped_io_pkg.sv | 39 +++
 rtl/io_edge_sync.sv | 37 +++
 rtl/wrapped_io_ctrl.sv | 155 +++++++++++++++
 tb/tb_wrapped_io_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrapped_io_pkg.sv
// Shared constants for the pad-control wrapper: register offsets, widths, reset values
// and the Wishbone byte-lane helpers.
package wrapped_io_pkg;

    localparam int REG_W    = 32;
    localparam int PAD_MAX  = 64;
    localparam int OFF_W    = 8;

    localparam logic [OFF_W-1:0] OFF_MODE_LO     = 8'h00;
    localparam logic [OFF_W-1:0] OFF_MODE_HI     = 8'h04;
    localparam logic [OFF_W-1:0] OFF_OEB_LO      = 8'h08;
    localparam logic [OFF_W-1:0] OFF_OEB_HI      = 8'h0C;
    localparam logic [OFF_W-1:0] OFF_GPIO_LO     = 8'h10;
    localparam logic [OFF_W-1:0] OFF_GPIO_HI     = 8'h14;
    localparam logic [OFF_W-1:0] OFF_IN_LO       = 8'h18;
    localparam logic [OFF_W-1:0] OFF_IN_HI       = 8'h1C;
    localparam logic [OFF_W-1:0] OFF_IRQ_EN_LO   = 8'h20;
    localparam logic [OFF_W-1:0] OFF_IRQ_EN_HI   = 8'h24;
    localparam logic [OFF_W-1:0] OFF_IRQ_STAT_LO = 8'h28;
    localparam logic [OFF_W-1:0] OFF_IRQ_STAT_HI = 8'h2C;

    localparam logic [PAD_MAX-1:0] RST_MODE   = {PAD_MAX{1'b1}};
    localparam logic [PAD_MAX-1:0] RST_OEB    = {PAD_MAX{1'b1}};
    localparam logic [PAD_MAX-1:0] RST_GPIO   = '0;
    localparam logic [PAD_MAX-1:0] RST_IRQ_EN = '0;

    function automatic logic [REG_W-1:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [REG_W-1:0] byte_merge(input logic [REG_W-1:0] old_v,
                                                    input logic [REG_W-1:0] new_v,
                                                    input logic [3:0]       sel);
        logic [REG_W-1:0] m;
        m = byte_mask(sel);
        return (old_v & ~m) | (new_v & m);
    endfunction

endpackage

// File: rtl/io_edge_sync.sv
// Two-flop synchroniser for asynchronous pad inputs with a third flop for rising-edge detect.
module io_edge_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] s1_d, s1_q;
    logic [WIDTH-1:0] s2_d, s2_q;
    logic [WIDTH-1:0] s3_d, s3_q;

    always_comb begin
        s1_d = d_i;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign sync_o = s2_q;
    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/wrapped_io_ctrl.sv
// Caravel pad-control wrapper: Wishbone register bank, per-pad project/register mux,
// synchronised input readback and a rising-edge pad interrupt.
module wrapped_io_ctrl
    import wrapped_io_pkg::*;
#(
    parameter int          NUM_PADS  = 38,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_PADS-1:0] proj_out,
    input  logic [NUM_PADS-1:0] proj_oeb,
    input  logic [1:0]          proj_irq,
    input  logic [NUM_PADS-1:0] io_in,
    output logic [NUM_PADS-1:0] io_out,
    output logic [NUM_PADS-1:0] io_oeb,
    output logic [2:0]          irq
);

    // Bits at or above NUM_PADS are tied to zero in every register.
    localparam logic [PAD_MAX-1:0] PAD_MASK =
        (NUM_PADS >= PAD_MAX) ? {PAD_MAX{1'b1}} : ((64'd1 << NUM_PADS) - 64'd1);

    logic [PAD_MAX-1:0] mode_d, mode_q;
    logic [PAD_MAX-1:0] oeb_d, oeb_q;
    logic [PAD_MAX-1:0] gpio_d, gpio_q;
    logic [PAD_MAX-1:0] en_d, en_q;
    logic [PAD_MAX-1:0] stat_d, stat_q;
    logic               irq_d, irq_q;
    logic               ack_d, ack_q;
    logic [REG_W-1:0]   dat_d, dat_q;

    logic [NUM_PADS-1:0] sync_w, rise_w;
    logic [PAD_MAX-1:0]  sync_64, rise_64, stat_clr;
    logic [OFF_W-1:0]    off;
    logic                hit, wr, rd;
    logic [REG_W-1:0]    rdata;

    io_edge_sync #(.WIDTH(NUM_PADS)) u_sync (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .d_i    (io_in),
        .sync_o (sync_w),
        .rise_o (rise_w)
    );

    always_comb begin
        sync_64 = '0;
        rise_64 = '0;
        sync_64[NUM_PADS-1:0] = sync_w;
        rise_64[NUM_PADS-1:0] = rise_w;
    end

    // A hit is blocked during the ack cycle so a held strobe cannot double-commit.
    always_comb begin
        off = {wbs_adr_i[7:2], 2'b00};
        hit = wbs_cyc_i && wbs_stb_i && ((wbs_adr_i & ADDR_MASK) == BASE_ADDR) && !ack_q;
        wr  = hit && wbs_we_i;
        rd  = hit && !wbs_we_i;
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_MODE_LO:     rdata = mode_q[31:0];
            OFF_MODE_HI:     rdata = mode_q[63:32];
            OFF_OEB_LO:      rdata = oeb_q[31:0];
            OFF_OEB_HI:      rdata = oeb_q[63:32];
            OFF_GPIO_LO:     rdata = gpio_q[31:0];
            OFF_GPIO_HI:     rdata = gpio_q[63:32];
            OFF_IN_LO:       rdata = sync_64[31:0];
            OFF_IN_HI:       rdata = sync_64[63:32];
            OFF_IRQ_EN_LO:   rdata = en_q[31:0];
            OFF_IRQ_EN_HI:   rdata = en_q[63:32];
            OFF_IRQ_STAT_LO: rdata = stat_q[31:0];
            OFF_IRQ_STAT_HI: rdata = stat_q[63:32];
            default:         rdata = '0;
        endcase
    end

    always_comb begin
        mode_d   = mode_q;
        oeb_d    = oeb_q;
        gpio_d   = gpio_q;
        en_d     = en_q;
        stat_clr = '0;
        if (wr) begin
            case (off)
                OFF_MODE_LO:     mode_d[31:0]    = byte_merge(mode_q[31:0],  wbs_dat_i, wbs_sel_i);
                OFF_MODE_HI:     mode_d[63:32]   = byte_merge(mode_q[63:32], wbs_dat_i, wbs_sel_i);
                OFF_OEB_LO:      oeb_d[31:0]     = byte_merge(oeb_q[31:0],   wbs_dat_i, wbs_sel_i);
                OFF_OEB_HI:      oeb_d[63:32]    = byte_merge(oeb_q[63:32],  wbs_dat_i, wbs_sel_i);
                OFF_GPIO_LO:     gpio_d[31:0]    = byte_merge(gpio_q[31:0],  wbs_dat_i, wbs_sel_i);
                OFF_GPIO_HI:     gpio_d[63:32]   = byte_merge(gpio_q[63:32], wbs_dat_i, wbs_sel_i);
                OFF_IRQ_EN_LO:   en_d[31:0]      = byte_merge(en_q[31:0],    wbs_dat_i, wbs_sel_i);
                OFF_IRQ_EN_HI:   en_d[63:32]     = byte_merge(en_q[63:32],   wbs_dat_i, wbs_sel_i);
                OFF_IRQ_STAT_LO: stat_clr[31:0]  = wbs_dat_i & byte_mask(wbs_sel_i);
                OFF_IRQ_STAT_HI: stat_clr[63:32] = wbs_dat_i & byte_mask(wbs_sel_i);
                default: ;
            endcase
        end
        mode_d = mode_d & PAD_MASK;
        oeb_d  = oeb_d  & PAD_MASK;
        gpio_d = gpio_d & PAD_MASK;
        en_d   = en_d   & PAD_MASK;
        // New edges are OR-ed in after the clear, so a coincident set survives.
        stat_d = ((stat_q & ~stat_clr) | (rise_64 & en_q)) & PAD_MASK;
        irq_d  = |(stat_q & en_q);
        ack_d  = hit;
        dat_d  = rd ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            mode_q <= RST_MODE & PAD_MASK;
            oeb_q  <= RST_OEB & PAD_MASK;
            gpio_q <= RST_GPIO;
            en_q   <= RST_IRQ_EN;
            stat_q <= '0;
            irq_q  <= 1'b0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            mode_q <= mode_d;
            oeb_q  <= oeb_d;
            gpio_q <= gpio_d;
            en_q   <= en_d;
            stat_q <= stat_d;
            irq_q  <= irq_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
        end
    end

    always_comb begin
        io_out = (mode_q[NUM_PADS-1:0] & gpio_q[NUM_PADS-1:0]) |
                 (~mode_q[NUM_PADS-1:0] & proj_out);
        io_oeb = (mode_q[NUM_PADS-1:0] & oeb_q[NUM_PADS-1:0]) |
                 (~mode_q[NUM_PADS-1:0] & proj_oeb);
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = {proj_irq, irq_q};

endmodule

// File: tb/tb_wrapped_io_ctrl.sv
// Directed and randomised checks of the pad-control wrapper against a register-level model.
module tb_wrapped_io_ctrl;

    localparam int          NP    = 38;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [63:0] PMASK = (64'd1 << NP) - 64'd1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stb, cyc, we;
    logic [3:0]    sel;
    logic [31:0]   adr, wdat;
    logic          ack;
    logic [31:0]   rdat;
    logic [NP-1:0] proj_out, proj_oeb, io_in, io_out, io_oeb;
    logic [1:0]    proj_irq;
    logic [2:0]    irq;

    int checks = 0;
    int errors = 0;

    // Register-level reference model
    logic [63:0] m_mode, m_oeb, m_gpio, m_en, m_stat;

    always #5 clk = ~clk;

    wrapped_io_ctrl #(.NUM_PADS(NP), .BASE_ADDR(BASE), .ADDR_MASK(32'hFFFF_FF00)) dut (
        .wb_clk_i (clk),      .wb_rst_ni (rst_n),
        .wbs_stb_i(stb),      .wbs_cyc_i (cyc),     .wbs_we_i (we),
        .wbs_sel_i(sel),      .wbs_adr_i (adr),     .wbs_dat_i(wdat),
        .wbs_ack_o(ack),      .wbs_dat_o (rdat),
        .proj_out (proj_out), .proj_oeb  (proj_oeb), .proj_irq(proj_irq),
        .io_in    (io_in),    .io_out    (io_out),  .io_oeb   (io_oeb),
        .irq      (irq)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] apply_bytes(input logic [63:0] r, input bit hi,
                                                input logic [31:0] d, input logic [3:0] s);
        logic [63:0] v;
        v = r;
        for (int b = 0; b < 4; b++)
            if (s[b]) v[(hi ? 32 : 0) + b*8 +: 8] = d[b*8 +: 8];
        return v & PMASK;
    endfunction

    task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        bit hi;
        logic [63:0] clr;
        hi = off[2];
        case (off & 8'hF8)
            8'h00: m_mode = apply_bytes(m_mode, hi, d, s);
            8'h08: m_oeb  = apply_bytes(m_oeb,  hi, d, s);
            8'h10: m_gpio = apply_bytes(m_gpio, hi, d, s);
            8'h20: m_en   = apply_bytes(m_en,   hi, d, s);
            8'h28: begin
                clr = apply_bytes(64'd0, hi, d, s);
                m_stat = m_stat & ~clr;
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off, input logic [63:0] pins);
        logic [63:0] r;
        case (off & 8'hF8)
            8'h00:   r = m_mode;
            8'h08:   r = m_oeb;
            8'h10:   r = m_gpio;
            8'h18:   r = pins & PMASK;
            8'h20:   r = m_en;
            8'h28:   r = m_stat;
            default: r = '0;
        endcase
        return off[2] ? r[63:32] : r[31:0];
    endfunction

    function automatic logic [63:0] model_out();
        return ((m_mode & m_gpio) | (~m_mode & 64'(proj_out))) & PMASK;
    endfunction

    function automatic logic [63:0] model_oeb();
        return ((m_mode & m_oeb) | (~m_mode & 64'(proj_oeb))) & PMASK;
    endfunction

    task automatic model_reset();
        m_mode = PMASK; m_oeb = PMASK; m_gpio = '0; m_en = '0; m_stat = '0;
    endtask

    // Called at a negedge; returns at the following negedge with the bus idle.
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit got;
        cyc = 1; stb = 1; we = 1; adr = a; wdat = d; sel = s; got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1;
        end
        check("wr_ack", 64'(got), 64'd1);
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        bit got;
        cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hF; got = 0; d = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1; d = rdat; end
        end
        check("rd_ack", 64'(got), 64'd1);
        @(negedge clk);
        cyc = 0; stb = 0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        wb_write(BASE + 32'(off), d, s);
        model_write(off, d, s);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] off);
        logic [31:0] d;
        wb_read(BASE + 32'(off), d);
        check(tag, 64'(d), 64'(model_read(off, 64'(io_in))));
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  rw_offs [8];
        logic [63:0] rnd_in;
        logic [63:0] exp_stat;
        bit          got;

        rw_offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24};
        rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        proj_out = '0; proj_oeb = '0; proj_irq = 2'b00; io_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Reset state
        check("rst_io_oeb", 64'(io_oeb), PMASK);
        check("rst_io_out", 64'(io_out), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_dat", 64'(rdat), 64'd0);
        wb_read(BASE + 32'h00, d);
        check("rst_mode_lo", 64'(d), 64'hFFFF_FFFF);
        wb_read(BASE + 32'h04, d);
        check("rst_mode_hi", 64'(d), 64'h3F);

        // Project drives the pad when MODE=0
        wr(8'h00, 32'h0, 4'hF);
        proj_out = '0; proj_out[5] = 1'b1;
        proj_oeb = '1; proj_oeb[5] = 1'b0;
        #1;
        check("proj_out5", 64'(io_out[5]), 64'd1);
        check("proj_oeb5", 64'(io_oeb[5]), 64'd0);
        @(negedge clk);

        // Byte-lane writes
        wr(8'h00, 32'hFFFF_FFFF, 4'hF);
        wr(8'h08, 32'h0, 4'hF);
        wr(8'h10, 32'h0000_00A5, 4'b0001);
        check("gpio_a5", 64'(io_out[7:0]), 64'hA5);
        check("oeb_lo0", 64'(io_oeb[31:0]), 64'd0);
        wr(8'h10, 32'h0000_00FF, 4'b0000);
        check("gpio_sel0", 64'(io_out[7:0]), 64'hA5);
        rd_check("gpio_lo_rb", 8'h10);

        // Pad edge interrupt on pad 33
        wr(8'h24, 32'h2, 4'hF);
        io_in[33] = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("irq_lat3", 64'(irq[0]), 64'd0);
        @(posedge clk);
        #1 check("irq_lat4", 64'(irq[0]), 64'd1);
        @(negedge clk);
        io_in[33] = 1'b0;
        wb_read(BASE + 32'h2C, d);
        check("stat_hi_set", 64'(d), 64'h2);
        wb_write(BASE + 32'h2C, 32'h2, 4'hF);
        @(posedge clk);
        #1 check("irq_w1c", 64'(irq[0]), 64'd0);
        @(negedge clk);
        repeat (4) @(negedge clk);
        io_in[33] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        wb_write(BASE + 32'h2C, 32'h2, 4'hF);
        wb_read(BASE + 32'h2C, d);
        check("stat_set_wins", 64'(d), 64'h2);
        check("irq_set_wins", 64'(irq[0]), 64'd1);
        io_in[33] = 1'b0;
        m_stat = 64'd1 << 33;

        // Random register traffic with random project pins
        for (int i = 0; i < 30; i++) begin
            logic [7:0] off;
            off = rw_offs[$urandom_range(0, 7)];
            wr(off, $urandom, 4'($urandom_range(0, 15)));
            proj_out = NP'({$urandom, $urandom});
            proj_oeb = NP'({$urandom, $urandom});
            proj_irq = 2'($urandom_range(0, 3));
            #1;
            check("rnd_io_out", 64'(io_out), model_out());
            check("rnd_io_oeb", 64'(io_oeb), model_oeb());
            check("rnd_proj_irq", 64'(irq[2:1]), 64'(proj_irq));
            @(negedge clk);
            rd_check("rnd_readback", off);
        end

        // Random edges against random enables
        for (int i = 0; i < 4; i++) begin
            wr(8'h20, $urandom, 4'hF);
            wr(8'h24, $urandom, 4'hF);
            wr(8'h28, 32'hFFFF_FFFF, 4'hF);
            wr(8'h2C, 32'hFFFF_FFFF, 4'hF);
            rnd_in = {$urandom, $urandom} & PMASK;
            io_in = NP'(rnd_in);
            repeat (5) @(negedge clk);
            exp_stat = rnd_in & m_en;
            m_stat = exp_stat;
            check("rnd_irq0", 64'(irq[0]), 64'(|exp_stat));
            rd_check("rnd_stat_lo", 8'h28);
            rd_check("rnd_stat_hi", 8'h2C);
            rd_check("rnd_in_lo", 8'h18);
            rd_check("rnd_in_hi", 8'h1C);
            io_in = '0;
            repeat (4) @(negedge clk);
        end

        // Out-of-window miss, then unmapped in-window offset with a held strobe
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h100; got = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack) got = 1;
        end
        check("miss_no_ack", 64'(got), 64'd0);
        @(negedge clk);
        adr = BASE + 32'h30;
        @(posedge clk); #1;
        check("unmapped_ack", 64'(ack), 64'd1);
        check("unmapped_dat", 64'(rdat), 64'd0);
        @(posedge clk); #1;
        check("no_rehit", 64'(ack), 64'd0);
        @(negedge clk);
        cyc = 0; stb = 0;
        @(negedge clk);

        // Reset in the middle of an acked write
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h00; wdat = 32'h1234_5678; sel = 4'hF;
        @(posedge clk); #1;
        check("pre_rst_ack", 64'(ack), 64'd1);
        #2 rst_n = 0;
        #1;
        check("rst_ack_drop", 64'(ack), 64'd0);
        check("rst_oeb_all1", 64'(io_oeb), PMASK);
        cyc = 0; stb = 0; we = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        rd_check("post_rst_mode", 8'h00);
        check("post_rst_out", 64'(io_out), model_out());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
